// File: rtl/fifo_pkg.sv
// fifo_pkg
// Shared definitions for the fifo_syn write-side logic.
//   clogb2      : bit width needed to hold values 0..value-1 (minimum 1)
//   arb_state_t : arbiter state encoding (ST_IDLE, ST_OWN)
package fifo_pkg;

    // Ceiling log2, clamped to at least one bit so that degenerate
    // parameters still produce a legal vector width.
    function automatic int clogb2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rr_pick
// Combinational round-robin selector.
//   valid : NREQ-bit request vector
//   ptr   : index that has highest priority this round
//   pick  : one-hot index of the first valid bit at or after ptr (wrapping)
//   any   : high when at least one valid bit is set
module rr_pick
    import fifo_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]          valid,
    input  logic [clogb2(NREQ)-1:0]  ptr,
    output logic [NREQ-1:0]          pick,
    output logic                     any
);

    localparam int PW = clogb2(NREQ);

    logic [PW-1:0] idx;
    logic          found;

    // Walk the requesters starting at ptr and take the first valid one.
    always_comb begin
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = PW'((int'(ptr) + k) % NREQ);
            if (!found && valid[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    assign any = |valid;

endmodule

// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb
// Round-robin arbiter sharing one fifo_syn write port among NREQ
// valid/ready/last requesters. A grant lasts up to BURST beats, ends early
// on a packet end or an owner bubble, and costs one idle arbitration cycle.
//   clk, rst    : clock, synchronous active-high reset
//   req_valid   : per-requester valid
//   req_data    : requester i at bits [i*WIDTH +: WIDTH]
//   req_last    : per-requester end-of-packet
//   req_ready   : per-requester accept (one-hot or zero)
//   grant       : registered one-hot owner, zero when idle
//   fifo_wr_req : write strobe into fifo_syn
//   fifo_data   : write data into fifo_syn
//   fifo_full   : fifo_syn full flag
//   busy        : high while a grant is held
module fifo_wr_arb
    import fifo_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int BURST = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    input  logic [NREQ-1:0]       req_last,
    output logic [NREQ-1:0]       req_ready,
    output logic [NREQ-1:0]       grant,
    output logic                  fifo_wr_req,
    output logic [WIDTH-1:0]      fifo_data,
    input  logic                  fifo_full,
    output logic                  busy
);

    localparam int PW = clogb2(NREQ);
    localparam int CW = clogb2(BURST + 1);

    arb_state_t       state, state_next;
    logic [NREQ-1:0]  grant_next;
    logic [PW-1:0]    rr_ptr, rr_ptr_next;
    logic [CW-1:0]    beat_cnt, beat_cnt_next, beat_inc;

    logic [NREQ-1:0]  pick;
    logic             pick_any;

    logic             owner_valid;
    logic             owner_last;
    logic [PW-1:0]    owner_idx;
    logic [WIDTH-1:0] owner_data;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .pick  (pick),
        .any   (pick_any)
    );

    // Route the owner's signals; grant is one-hot or zero, so OR-ing the
    // selected lanes is a mux that naturally yields zero when idle.
    always_comb begin
        owner_valid = |(req_valid & grant);
        owner_last  = |(req_last & grant);
        owner_data  = '0;
        owner_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                owner_data = owner_data | req_data[i*WIDTH +: WIDTH];
                owner_idx  = PW'(i);
            end
        end
    end

    // Handshake is combinational on fifo_full so no write ever lands in a
    // full FIFO.
    assign req_ready   = fifo_full ? '0 : grant;
    assign fifo_wr_req = owner_valid & ~fifo_full;
    assign fifo_data   = owner_data;
    assign busy        = (state == ST_OWN);
    assign beat_inc    = beat_cnt + 1'b1;

    // Next-state logic: arbitrate in IDLE, count beats and decide release
    // in OWN. A full FIFO is a stall and never ends the grant.
    always_comb begin
        state_next    = state;
        grant_next    = grant;
        rr_ptr_next   = rr_ptr;
        beat_cnt_next = beat_cnt;
        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    state_next    = ST_OWN;
                    grant_next    = pick;
                    beat_cnt_next = '0;
                end
            end
            ST_OWN: begin
                if (!fifo_full) begin
                    if (owner_valid) begin
                        beat_cnt_next = beat_inc;
                    end
                    if (!owner_valid || owner_last || (beat_inc == CW'(BURST))) begin
                        state_next    = ST_IDLE;
                        grant_next    = '0;
                        beat_cnt_next = '0;
                        rr_ptr_next   = (owner_idx == PW'(NREQ - 1)) ? '0 : owner_idx + 1'b1;
                    end
                end
            end
            default: begin
                state_next    = ST_IDLE;
                grant_next    = '0;
                beat_cnt_next = '0;
            end
        endcase
    end

    // State register; reset abandons any burst in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            grant    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_next;
            grant    <= grant_next;
            rr_ptr   <= rr_ptr_next;
            beat_cnt <= beat_cnt_next;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb_fifo_wr_arb
// Randomized bench for fifo_wr_arb against an integer-level reference
// model of the round-robin grant rules, checked once per cycle.
module tb_fifo_wr_arb;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int BURST = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_last;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       grant;
    logic                  fifo_wr_req;
    logic [WIDTH-1:0]      fifo_data;
    logic                  fifo_full;
    logic                  busy;

    int num_vectors = 0;
    int num_errors  = 0;

    // Requester-side stream state
    logic [NREQ-1:0]  cur_valid = '0;
    logic [NREQ-1:0]  cur_last  = '0;
    logic [WIDTH-1:0] cur_data [NREQ];
    logic [NREQ-1:0]  accepted  = '0;

    // Reference model: owner index (-1 idle), priority pointer, beats taken
    int m_owner = -1;
    int m_ptr   = 0;
    int m_cnt   = 0;

    fifo_wr_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .BURST(BURST)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .grant       (grant),
        .fifo_wr_req (fifo_wr_req),
        .fifo_data   (fifo_data),
        .fifo_full   (fifo_full),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        num_vectors++;
        if (observed !== expected) begin
            num_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Drive one cycle of requester inputs; a pending unaccepted beat is held.
    task automatic applyStimulus(input logic [NREQ-1:0] want, input int last_pct,
                                 input bit full, input bit rst_in);
        for (int i = 0; i < NREQ; i++) begin
            if (!(cur_valid[i] && !accepted[i])) begin
                cur_valid[i] = want[i];
                cur_data[i]  = WIDTH'($urandom);
                cur_last[i]  = ($urandom_range(99) < last_pct);
            end
            req_data[i*WIDTH +: WIDTH] = cur_data[i];
        end
        req_valid = cur_valid;
        req_last  = cur_last;
        fifo_full = full;
        rst       = rst_in;
    endtask

    // Compare this cycle's outputs with the model, then advance the model
    // through the coming clock edge.
    task automatic stepCycle(input logic [NREQ-1:0] want, input int last_pct,
                             input bit full, input bit rst_in);
        logic [NREQ-1:0]  exp_grant;
        logic [NREQ-1:0]  exp_ready;
        logic             exp_wr;
        logic [WIDTH-1:0] exp_data;
        int               idx;

        applyStimulus(want, last_pct, full, rst_in);
        #4;

        exp_grant = '0;
        exp_data  = '0;
        exp_wr    = 1'b0;
        if (m_owner >= 0) begin
            exp_grant[m_owner] = 1'b1;
            exp_data           = cur_data[m_owner];
            exp_wr             = cur_valid[m_owner] && !full;
        end
        exp_ready = full ? '0 : exp_grant;

        checkOutput("grant",       32'(grant),       32'(exp_grant));
        checkOutput("req_ready",   32'(req_ready),   32'(exp_ready));
        checkOutput("fifo_wr_req", 32'(fifo_wr_req), 32'(exp_wr));
        checkOutput("fifo_data",   32'(fifo_data),   32'(exp_data));
        checkOutput("busy",        32'(busy),        32'(m_owner >= 0));

        accepted = exp_ready & cur_valid;

        if (rst_in) begin
            m_owner = -1;
            m_ptr   = 0;
            m_cnt   = 0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_ptr + k) % NREQ;
                if (m_owner < 0 && cur_valid[idx]) begin
                    m_owner = idx;
                    m_cnt   = 0;
                end
            end
        end else if (!full) begin
            if (!cur_valid[m_owner]) begin
                m_ptr   = (m_owner + 1) % NREQ;
                m_owner = -1;
            end else begin
                m_cnt++;
                if (cur_last[m_owner] || m_cnt == BURST) begin
                    m_ptr   = (m_owner + 1) % NREQ;
                    m_owner = -1;
                    m_cnt   = 0;
                end
            end
        end

        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) cur_data[i] = '0;
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        fifo_full = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state with nothing requesting
        stepCycle(4'b0000, 0, 1'b0, 1'b0);
        stepCycle(4'b0000, 0, 1'b0, 1'b0);

        // Single requester, short packets
        repeat (12) stepCycle(4'b0001, 35, 1'b0, 1'b0);
        repeat (3)  stepCycle(4'b0000, 0, 1'b0, 1'b0);

        // All requesters continuously valid, bursts limited by BURST
        repeat (30) stepCycle(4'b1111, 0, 1'b0, 1'b0);

        // FIFO full stalls mid-burst
        repeat (40) stepCycle(4'b1111, 0, ($urandom_range(99) < 40), 1'b0);

        // Owner bubbles: valid toggles randomly, FIFO never full
        repeat (40) stepCycle(NREQ'($urandom), 20, 1'b0, 1'b0);

        // Reset in the middle of a requester 1 burst, then 0 and 1 compete
        repeat (3) stepCycle(4'b0010, 0, 1'b0, 1'b0);
        stepCycle(4'b0010, 0, 1'b0, 1'b1);
        repeat (10) stepCycle(4'b0011, 0, 1'b0, 1'b0);

        // Requesters 1 and 3 only, single-beat packets
        repeat (16) stepCycle(4'b1010, 100, 1'b0, 1'b0);

        // Fully random traffic with occasional resets
        repeat (400) stepCycle(NREQ'($urandom), 25, ($urandom_range(99) < 25),
                               ($urandom_range(99) < 2));

        $display("== %0d vectors applied, %0d miscompares ==", num_vectors, num_errors);
        $finish;
    end

endmodule
